// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data bus, lane alignment and timeout
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        flush,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_DMType,
  input  logic [31:0] i_ALU_out,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_Read_Data,
  output logic        o_valid,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [2:0]  dt_q;
  logic [1:0]  off_q;
  logic        kill;
  logic [31:0] rd_q;

  logic        is_half, is_byte, is_word;
  logic        access, mis, issue, timeout;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_c;

  // Last BUSY cycle before the access is abandoned (counter starts at 0 in the first BUSY cycle).
  assign timeout = (cnt == 8'(TIMEOUT_CYCLES - 1));

  // The read-data register is only presented while the result is being handed to MEM/WB.
  assign o_Read_Data = (state == DONE) ? rd_q : 32'h0;

  // Decode the incoming access: size, alignment, byte enables and lane-replicated store data.
  always_comb begin
    is_half = (i_DMType == 3'b001) || (i_DMType == 3'b010);
    is_byte = (i_DMType == 3'b011) || (i_DMType == 3'b100);
    is_word = !is_half && !is_byte;
    access  = i_valid & (i_MemRead | i_MemWrite) & ~flush;
    mis     = access & ((is_half & i_ALU_out[0]) | (is_word & (i_ALU_out[1:0] != 2'b00)));
    issue   = access & ~mis;
    if (is_byte) begin
      be_c = 4'b0001 << i_ALU_out[1:0];
      wd_c = {4{i_store_data[7:0]}};
    end else if (is_half) begin
      be_c = i_ALU_out[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{i_store_data[15:0]}};
    end else begin
      be_c = 4'b1111;
      wd_c = i_store_data;
    end
  end

  // Pick the addressed lane of the returned word and extend it per the latched access type.
  always_comb begin
    ld_b = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (dt_q)
      3'b001:  ld_c = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_c = {16'h0, ld_h};
      3'b011:  ld_c = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_c = {24'h0, ld_b};
      default: ld_c = dmem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and pipeline handshake outputs.
  always_comb begin
    state_nx     = state;
    o_stall      = 1'b0;
    o_valid      = 1'b0;
    o_misaligned = 1'b0;
    o_bus_err    = 1'b0;
    case (state)
      IDLE: begin
        o_misaligned = mis;
        if (issue) begin
          o_stall  = 1'b1;
          state_nx = BUSY;
        end else begin
          o_valid = i_valid & ~flush & ~mis;
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (dmem_ack) begin
          state_nx = DONE;
        end else if (timeout) begin
          o_bus_err = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        o_valid  = ~kill;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus request, latched access attributes, timeout counter, kill flag and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_be    <= 4'h0;
      dmem_wdata <= 32'h0;
      dt_q       <= 3'b000;
      off_q      <= 2'b00;
      cnt        <= 8'h0;
      kill       <= 1'b0;
      rd_q       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= i_MemWrite;
            dmem_addr  <= {i_ALU_out[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wd_c;
            dt_q       <= i_DMType;
            off_q      <= i_ALU_out[1:0];
            cnt        <= 8'h0;
            kill       <= 1'b0;
            rd_q       <= 32'h0;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'h1;
          // A flush cannot abort a bus cycle already in flight, only discard its result.
          if (flush) kill <= 1'b1;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            rd_q     <= dmem_we ? 32'h0 : ld_c;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            kill     <= 1'b1;
          end
        end
        DONE: kill <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Issues data-memory transactions over a req/ack bus and aligns store data into byte lanes.
- Sign- or zero-extends load data and drives the MEM/WB register's read-data and valid inputs.
- Holds the pipeline with o_stall until the bus completes, times out, or flags a misaligned access.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in BUSY without dmem_ack before the access is abandoned as a bus error (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; unit is reset while reset==0
i_valid  input  1  EX/MEM entry valid
flush  input  1  kill current MEM-stage instruction
i_MemRead  input  1  load
i_MemWrite  input  1  store
i_DMType  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
i_ALU_out  input  32  effective address
i_store_data  input  32  rs2 value
o_Read_Data  output  32  extended load data (to MEM/WB i_Read_Data)
o_valid  output  1  to MEM/WB i_valid
o_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
o_misaligned  output  1  misaligned-access exception, one cycle
o_bus_err  output  1  timeout pulse, one cycle
dmem_req  output  1  bus request, held until ack
dmem_we  output  1  write enable
dmem_addr  output  32  {i_ALU_out[31:2],2'b00}, latched
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  transaction complete; dmem_rdata valid the same cycle
dmem_rdata  input  32  read word

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (reset==0, async): state IDLE; timeout counter 0; all registered outputs 0.
  - Registered outputs are dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, the o_Read_Data register and the kill flag.
  - dmem_req drops immediately, even mid-BUSY.
- Definitions:
  - access = i_valid & (i_MemRead|i_MemWrite) & ~flush.
  - mis = access & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - issue = access & ~mis.
  - MemRead and MemWrite both set: treated as a store.
- IDLE, no issue:
  - o_valid = i_valid & ~flush & ~mis.
  - o_stall = 0; o_Read_Data = 0.
  - o_misaligned = mis. Misaligned accesses generate no bus activity.
- IDLE, issue:
  - o_stall = 1 combinationally in the same cycle; o_valid = 0.
  - At the clock edge: latch bus signals, assert dmem_req, enter BUSY.
- Byte lanes:
  - Byte: be = 1<<addr[1:0]; wdata = {4{d[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{d[15:0]}}.
  - Word: be = 1111.
  - Loads use the same be with we=0.
- BUSY:
  - o_stall = 1; o_valid = 0; bus outputs stable; counter increments each cycle.
  - dmem_ack: capture dmem_rdata, select lane by latched addr[1:0], extend per latched DMType into the o_Read_Data register. Stores write 0. Drop req, go DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop req, pulse o_bus_err, set kill, go DONE.
  - ack and timeout in the same cycle: ack wins.
- flush while BUSY: the bus transaction is not aborted (a store still writes). The kill flag is set and the result is discarded.
- DONE (exactly 1 cycle):
  - o_stall = 0; o_valid = ~kill; o_Read_Data held.
  - The MEM/WB register and upstream stages advance at this edge.
  - Next state is IDLE and kill clears. DONE never re-issues even though the inputs still show the same instruction.
- Latency: a load with ack in cycle N+k (request issued at edge N) has o_valid=1 in cycle N+k+1. The minimum stall is 2 cycles (issue cycle + BUSY with an immediate ack).
- o_misaligned and o_bus_err never assert together.

Test Plan:
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> be=1111, we=0, o_stall high 4 cycles, DONE shows o_Read_Data=0xDEADBEEF, o_valid=1.
- LB signed addr 0x103, rdata 0x80112233 -> be=1000, o_Read_Data=0xFFFFFF80; same access as LBU -> 0x00000080; LH signed addr 0x102 -> 0xFFFF8011.
- SB addr 0x101, data 0x000000A5 -> dmem_wdata=0xA5A5A5A5, be=0010, we=1, o_Read_Data=0; SW addr 0x102 -> o_misaligned pulse, no dmem_req, o_valid=0, o_stall=0.
- No ack with TIMEOUT_CYCLES=4 -> dmem_req drops after 4 BUSY cycles, o_bus_err single pulse, DONE o_valid=0; ack coinciding with the timeout cycle -> normal completion, no o_bus_err.
- flush asserted during BUSY on a store -> store still completes on ack, DONE o_valid=0; flush in IDLE with a load -> no request, o_valid=0.
- reset driven 0 mid-BUSY -> dmem_req=0 immediately, state IDLE; after release a new LW issues normally.
